// File: rtl/gh_video_pkg.sv
// Shared video-path definitions for the guitar-player front end.
//   LUMA_K*      : BT.601-style luma weights scaled by 256 (they sum to 256)
//   VID_LATENCY  : pipeline depth from decoder inputs to binarised outputs
//   rgb_t        : one 24-bit pixel
//   vsync_t      : sync/enable bundle that travels alongside the pixel
//   thr_low/high : hysteresis band edges, clamped to the 8-bit luma range
package gh_video_pkg;

  localparam int LUMA_KR     = 77;
  localparam int LUMA_KG     = 150;
  localparam int LUMA_KB     = 29;
  localparam int VID_LATENCY = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vsync_t;

  function automatic logic [7:0] thr_low(input logic [7:0] t, input logic [3:0] h);
    return (t > {4'd0, h}) ? (t - {4'd0, h}) : 8'd0;
  endfunction

  function automatic logic [7:0] thr_high(input logic [7:0] t, input logic [3:0] h);
    logic [8:0] s;
    s = {1'b0, t} + {5'd0, h};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/pixel_binarizer_luma_pipe.sv
// First two pipeline stages of the binariser: RGB -> 8-bit luma.
//   clk, rst_n           : pixel clock, synchronous active-low reset
//   red, green, blue     : input pixel components
//   hsync, vsync, vde    : input sync / data enable
//   luma                 : Y, two cycles after the inputs
//   hsync_dly, vsync_dly,
//   vde_dly              : sync / enable delayed to stay aligned with luma
module luma_pipe
  import gh_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       vde,
  output logic [7:0] luma,
  output logic       hsync_dly,
  output logic       vsync_dly,
  output logic       vde_dly
);

  logic [15:0] pr, pg, pb;
  logic [15:0] sum;
  logic [7:0]  luma_q;
  vsync_t      sync_s1, sync_s2;

  // Weights sum to 256, so 255*256 = 65280 is the largest sum: no overflow.
  assign sum = pr + pg + pb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr      <= '0;
      pg      <= '0;
      pb      <= '0;
      sync_s1 <= '0;
      luma_q  <= '0;
      sync_s2 <= '0;
    end else begin
      pr      <= 16'(red)   * 16'(LUMA_KR);
      pg      <= 16'(green) * 16'(LUMA_KG);
      pb      <= 16'(blue)  * 16'(LUMA_KB);
      sync_s1 <= '{hs: hsync, vs: vsync, de: vde};
      luma_q  <= 8'(sum >> 8);
      sync_s2 <= sync_s1;
    end
  end

  assign luma      = luma_q;
  assign hsync_dly = sync_s2.hs;
  assign vsync_dly = sync_s2.vs;
  assign vde_dly   = sync_s2.de;

endmodule

// File: rtl/pixel_binarizer.sv
// Turns decoded RGB video into the 1-bit Pixel stream for the fret detectors,
// with per-line hysteresis and a per-frame bright-pixel count.
//   CLK, RST_N                 : pixel clock, synchronous active-low reset
//   HSync_in, VSync_in, VDE_in : decoder sync / data enable
//   Red, Green, Blue           : pixel components
//   Threshold                  : luma threshold, latched at each VSync_in rise
//   Hysteresis                 : band half-width, used live
//   Invert                     : 1 = dark pixels are reported as 1
//   HSync, VSync, VDE, Pixel   : outputs, 3 cycles after the inputs
//   BrightCount, CountValid    : last frame's Pixel=1 count and its update strobe
module pixel_binarizer
  import gh_video_pkg::*;
#(
  parameter logic [7:0] THRESH_DEFAULT = 8'd160,
  parameter int         CNT_W          = 21
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HSync_in,
  input  logic             VSync_in,
  input  logic             VDE_in,
  input  logic [7:0]       Red,
  input  logic [7:0]       Green,
  input  logic [7:0]       Blue,
  input  logic [7:0]       Threshold,
  input  logic [3:0]       Hysteresis,
  input  logic             Invert,
  output logic             HSync,
  output logic             VSync,
  output logic             VDE,
  output logic             Pixel,
  output logic [CNT_W-1:0] BrightCount,
  output logic             CountValid
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  rgb_t             px;
  logic [7:0]       y_s2;
  logic             hs_s2, vs_s2, de_s2;
  logic [7:0]       thr_act;
  logic             vs_in_q;
  logic             lvl;
  logic [CNT_W-1:0] acc;

  logic [7:0]       thr_eff;
  logic             raw;
  logic             pix_next;
  logic             vs_rise;
  logic [CNT_W-1:0] acc_next;

  assign px = '{r: Red, g: Green, b: Blue};

  luma_pipe u_luma (
    .clk       (CLK),
    .rst_n     (RST_N),
    .red       (px.r),
    .green     (px.g),
    .blue      (px.b),
    .hsync     (HSync_in),
    .vsync     (VSync_in),
    .vde       (VDE_in),
    .luma      (y_s2),
    .hsync_dly (hs_s2),
    .vsync_dly (vs_s2),
    .vde_dly   (de_s2)
  );

  always_comb begin
    thr_eff  = lvl ? thr_low(thr_act, Hysteresis) : thr_high(thr_act, Hysteresis);
    raw      = (y_s2 >= thr_eff);
    pix_next = de_s2 & (raw ^ Invert);
    // VSync still holds the previous output value, so this is the output edge
    // being formed this cycle; the pixel leaving with it closes the frame.
    vs_rise  = vs_s2 & ~VSync;
    acc_next = (pix_next && (acc != ACC_MAX)) ? (acc + CNT_W'(1)) : acc;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      HSync       <= 1'b0;
      VSync       <= 1'b0;
      VDE         <= 1'b0;
      Pixel       <= 1'b0;
      lvl         <= 1'b0;
      vs_in_q     <= 1'b0;
      thr_act     <= THRESH_DEFAULT;
      acc         <= '0;
      BrightCount <= '0;
      CountValid  <= 1'b0;
    end else begin
      HSync   <= hs_s2;
      VSync   <= vs_s2;
      VDE     <= de_s2;
      Pixel   <= pix_next;
      // Tracks raw rather than Pixel so Invert leaves segment edges alone.
      lvl     <= de_s2 & raw;
      vs_in_q <= VSync_in;
      if (VSync_in && !vs_in_q) begin
        thr_act <= Threshold;
      end
      if (vs_rise) begin
        BrightCount <= acc_next;
        acc         <= '0;
        CountValid  <= 1'b1;
      end else begin
        acc         <= acc_next;
        CountValid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_binarizer.sv
// Self-checking bench for pixel_binarizer: reset state, latency, hysteresis
// ramps, threshold timing, frame counts, mid-line reset, a table of threshold
// corner cases, then random video against a behavioural model.
module tb_pixel_binarizer;

  localparam int CNT_W   = 21;
  localparam int ACC_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, hs_i, vs_i, de_i, inv_i;
  logic [7:0]       r_i, g_i, b_i, thr_i;
  logic [3:0]       hy_i;
  logic             hs_o, vs_o, de_o, pix_o, cv_o;
  logic [CNT_W-1:0] bc_o;

  pixel_binarizer #(.THRESH_DEFAULT(8'd160), .CNT_W(CNT_W)) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .HSync_in    (hs_i),
    .VSync_in    (vs_i),
    .VDE_in      (de_i),
    .Red         (r_i),
    .Green       (g_i),
    .Blue        (b_i),
    .Threshold   (thr_i),
    .Hysteresis  (hy_i),
    .Invert      (inv_i),
    .HSync       (hs_o),
    .VSync       (vs_o),
    .VDE         (de_o),
    .Pixel       (pix_o),
    .BrightCount (bc_o),
    .CountValid  (cv_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: inputs wait in a two-deep queue, then are judged.
  int q_y[2];
  bit q_hs[2], q_vs[2], q_de[2];
  int m_thr, m_acc, m_bc;
  bit m_lvl, m_pix, m_hs, m_vs, m_de, m_cv, m_vsin;

  typedef struct {
    int t;
    int h;
    bit inv;
    int prev_y;
    int cur_y;
    bit expv;
  } row_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      q_y[i] = 0; q_hs[i] = 0; q_vs[i] = 0; q_de[i] = 0;
    end
    m_thr = 160; m_acc = 0; m_bc = 0;
    m_lvl = 0; m_pix = 0; m_hs = 0; m_vs = 0; m_de = 0; m_cv = 0; m_vsin = 0;
  endfunction

  task automatic tick();
    int h, lo, hi, te, s;
    bit ge, pix;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      h  = int'(hy_i);
      lo = (m_thr - h < 0) ? 0 : m_thr - h;
      hi = (m_thr + h > 255) ? 255 : m_thr + h;
      te = m_lvl ? lo : hi;
      ge = (q_y[1] >= te);
      pix = q_de[1] && (ge ^ inv_i);
      m_lvl = q_de[1] && ge;
      s = m_acc + int'(pix);
      if (s > ACC_MAX) s = ACC_MAX;
      if (q_vs[1] && !m_vs) begin
        m_bc = s; m_acc = 0; m_cv = 1;
      end else begin
        m_acc = s; m_cv = 0;
      end
      m_hs = q_hs[1]; m_vs = q_vs[1]; m_de = q_de[1]; m_pix = pix;
      if (vs_i && !m_vsin) m_thr = int'(thr_i);
      m_vsin = vs_i;
      q_y[1] = q_y[0]; q_hs[1] = q_hs[0]; q_vs[1] = q_vs[0]; q_de[1] = q_de[0];
      q_y[0] = (int'(r_i) * 77 + int'(g_i) * 150 + int'(b_i) * 29) >> 8;
      q_hs[0] = hs_i; q_vs[0] = vs_i; q_de[0] = de_i;
    end
    #1;
    chk("m_hsync", hs_o, m_hs);
    chk("m_vsync", vs_o, m_vs);
    chk("m_vde",   de_o, m_de);
    chk("m_pixel", pix_o, m_pix);
    chk("m_count", bc_o, m_bc);
    chk("m_valid", cv_o, m_cv);
  endtask

  task automatic set_px(input bit de, input int grey);
    de_i = de;
    r_i = 8'(grey); g_i = 8'(grey); b_i = 8'(grey);
  endtask

  task automatic vs_pulse(input int t);
    thr_i = 8'(t);
    set_px(0, 0);
    vs_i = 1; tick();
    vs_i = 0; tick(); tick();
  endtask

  task automatic line(input int grey, input int n, input bit expv, input string nm);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) set_px(1, grey); else set_px(0, 0);
      tick();
      if (i >= 2) chk(nm, pix_o, expv);
    end
  endtask

  task automatic close_frame(input int expc, input string nm);
    set_px(0, 0);
    repeat (4) tick();
    vs_i = 1;
    tick(); tick(); tick();
    chk({nm, "_vs"}, vs_o, 1);
    chk({nm, "_cv"}, cv_o, 1);
    chk({nm, "_bc"}, bc_o, expc);
    tick();
    chk({nm, "_cv_off"}, cv_o, 0);
    vs_i = 0;
    repeat (3) tick();
  endtask

  initial begin
    row_t rows[13];
    int ramp[42];
    bit ramp_exp[42];
    int cnt;

    rst_n = 0; hs_i = 0; vs_i = 0; de_i = 0;
    r_i = 0; g_i = 0; b_i = 0; thr_i = 8'd160; hy_i = 4'd4; inv_i = 0;
    m_reset();
    tick(); tick();
    chk("rst_pixel", pix_o, 0);
    chk("rst_vde",   de_o, 0);
    chk("rst_count", bc_o, 0);
    chk("rst_valid", cv_o, 0);
    rst_n = 1;

    // Latency with the default threshold, then Invert.
    set_px(1, 255);
    tick(); chk("lat_c1", pix_o, 0);
    tick(); chk("lat_c2", pix_o, 0);
    tick(); chk("lat_c3", pix_o, 1);
    chk("lat_vde", de_o, 1);
    inv_i = 1;
    tick(); chk("invert", pix_o, 0);
    inv_i = 0;
    set_px(0, 0);
    repeat (4) tick();

    // Hysteresis ramps on one line.
    hy_i = 4'd4;
    vs_pulse(160);
    for (int i = 0; i < 21; i++) begin
      ramp[i] = 150 + i;        ramp_exp[i] = (150 + i >= 164);
      ramp[21 + i] = 170 - i;   ramp_exp[21 + i] = (170 - i >= 156);
    end
    for (int i = 0; i < 44; i++) begin
      if (i < 42) set_px(1, ramp[i]); else set_px(0, 0);
      tick();
      if (i >= 2) chk("ramp", pix_o, ramp_exp[i - 2]);
    end

    // Threshold waits for the next frame edge.
    vs_pulse(160);
    thr_i = 8'd40;
    line(100, 10, 0, "thr_hold");
    vs_pulse(40);
    line(100, 10, 1, "thr_new");

    // Frame counts.
    thr_i = 8'd160;
    vs_pulse(160);
    cnt = 0;
    for (int l = 0; l < 25; l++) begin
      for (int p = 0; p < 80; p++) begin
        set_px(1, (cnt < 1000) ? 255 : 0);
        cnt++;
        tick();
      end
      set_px(0, 0);
      hs_i = 1; tick(); tick(); hs_i = 0; tick(); tick();
    end
    close_frame(1000, "frame1000");
    for (int l = 0; l < 5; l++) begin
      line(0, 40, 0, "dark_line");
      tick();
    end
    close_frame(0, "frame0");

    // Reset mid-line.
    line(255, 0, 0, "idle");
    for (int i = 0; i < 10; i++) begin set_px(1, 255); tick(); end
    rst_n = 0; tick();
    chk("mid_rst_pixel", pix_o, 0);
    chk("mid_rst_vde",   de_o, 0);
    chk("mid_rst_vs",    vs_o, 0);
    chk("mid_rst_hs",    hs_o, 0);
    chk("mid_rst_count", bc_o, 0);
    chk("mid_rst_valid", cv_o, 0);
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin set_px(1, 255); tick(); end
    close_frame(15, "post_rst");

    // Threshold/hysteresis corner cases: prev pixel sets the hysteresis state.
    rows[0]  = '{160, 4, 0,   0, 164, 1};
    rows[1]  = '{160, 4, 0,   0, 163, 0};
    rows[2]  = '{160, 4, 0, 200, 156, 1};
    rows[3]  = '{160, 4, 0, 200, 155, 0};
    rows[4]  = '{160, 4, 1, 200, 155, 1};
    rows[5]  = '{160, 4, 1, 255, 255, 0};
    rows[6]  = '{  2, 15, 0, 255,   0, 1};
    rows[7]  = '{  2, 15, 0,   0,   0, 0};
    rows[8]  = '{  2, 15, 0,   0, 255, 1};
    rows[9]  = '{250, 15, 0,   0, 255, 1};
    rows[10] = '{250, 15, 0,   0, 254, 0};
    rows[11] = '{250, 15, 0, 255, 235, 1};
    rows[12] = '{  0, 0, 0,    0,   0, 1};
    for (int k = 0; k < 13; k++) begin
      hy_i = 4'(rows[k].h);
      inv_i = rows[k].inv;
      vs_pulse(rows[k].t);
      set_px(1, rows[k].prev_y); tick();
      set_px(1, rows[k].cur_y);  tick();
      set_px(0, 0); tick(); tick();
      chk($sformatf("table_row%0d", k), pix_o, rows[k].expv);
      tick(); tick();
    end
    inv_i = 0;

    // Random video against the model.
    for (int f = 0; f < 12; f++) begin
      thr_i = 8'($urandom_range(0, 255));
      set_px(0, 0);
      vs_i = 1;
      repeat ($urandom_range(1, 3)) tick();
      vs_i = 0;
      repeat ($urandom_range(0, 4)) tick();
      for (int l = 0; l < int'($urandom_range(3, 6)); l++) begin
        hy_i = 4'($urandom_range(0, 15));
        inv_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) thr_i = 8'($urandom_range(0, 255));
        for (int p = 0; p < int'($urandom_range(5, 40)); p++) begin
          de_i = 1;
          if ($urandom_range(0, 1) == 0) begin
            r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
          end else begin
            set_px(1, $urandom_range(0, 255));
          end
          if ($urandom_range(0, 99) == 0) vs_i = ~vs_i;
          if ($urandom_range(0, 299) == 0) rst_n = 0;
          tick();
          rst_n = 1;
        end
        set_px(0, 0);
        hs_i = 1;
        repeat ($urandom_range(1, 3)) tick();
        hs_i = 0;
        repeat ($urandom_range(1, 3)) tick();
      end
      vs_i = 0;
      repeat (4) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
